// File: rtl/proc_host_ctrl.sv
// proc_host_ctrl
//   Host-side initiator for the processor's init/req/ack handshake. One job
//   holds the processor in init, preloads an input window of data memory from
//   a byte stream, pulses req and waits for ack (counting cycles, with an
//   optional timeout), then drains a result window to an output byte stream.
//   It owns the data-memory port only while the processor is idle.
//
// Ports
//   Clk, Reset                  clock, synchronous active-high reset
//   start                       begin a job (accepted in IDLE/DONE/TIMEOUT)
//   in_valid/in_ready/in_data   preload byte stream
//   proc_init/proc_req/proc_ack processor start-done handshake
//   mem_we/mem_addr/mem_wdata   data-memory write port (preload)
//   mem_rdata                   data-memory read data, combinational on mem_addr
//   out_valid/out_ready/out_data result byte stream
//   busy, done, timed_out       job status
//   cycle_count                 RUN cycles counted for the last/current job
module proc_host_ctrl #(
  parameter int W           = 8,
  parameter int A           = 8,
  parameter int LOAD_BASE   = 0,
  parameter int LOAD_LEN    = 64,
  parameter int RES_BASE    = 64,
  parameter int RES_LEN     = 64,
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 100000,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             proc_init,
  output logic             proc_req,
  input  logic             proc_ack,
  output logic             mem_we,
  output logic [A-1:0]     mem_addr,
  output logic [W-1:0]     mem_wdata,
  input  logic [W-1:0]     mem_rdata,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_START, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT
  } state_t;

  localparam logic [31:0]      LOAD_LAST   = 32'(LOAD_LEN - 1);
  localparam logic [31:0]      RES_LAST    = 32'(RES_LEN - 1);
  localparam logic [31:0]      INIT_LOAD   = 32'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [A-1:0]     LOAD_BASE_A = A'(LOAD_BASE);
  localparam logic [A-1:0]     RES_BASE_A  = A'(RES_BASE);

  state_t           state;
  logic [31:0]      idx;
  logic [31:0]      init_cnt;
  logic [CNT_W-1:0] cnt_next;

  // Cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cnt_next  = sat_inc(cycle_count);
  assign proc_init = Reset | (state == S_INIT);

  // Stream and memory strobes are decoded from state in the same cycle.
  // They are forced low while Reset is high so no handshake completes in
  // the reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    out_valid = 1'b0;
    out_data  = '0;
    proc_req  = 1'b0;
    busy      = 1'b0;
    if (!Reset) begin
      busy = state inside {S_INIT, S_LOAD, S_START, S_RUN, S_DRAIN};
      case (state)
        S_LOAD: begin
          in_ready  = 1'b1;
          mem_we    = in_valid;
          mem_addr  = LOAD_BASE_A + idx[A-1:0];
          mem_wdata = in_data;
        end
        S_DRAIN: begin
          mem_addr  = RES_BASE_A + idx[A-1:0];
          out_valid = 1'b1;
          out_data  = mem_rdata;
        end
        S_START: proc_req = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      init_cnt    <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state       <= S_INIT;
            idx         <= '0;
            init_cnt    <= INIT_LOAD;
            cycle_count <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
          end
        end
        S_INIT: begin
          // Counter holds the cycles left including this one.
          if (init_cnt <= 32'd1)
            state <= (LOAD_LEN == 0) ? S_START : S_LOAD;
          else
            init_cnt <= init_cnt - 32'd1;
        end
        S_LOAD: begin
          if (in_valid) begin
            idx <= idx + 32'd1;
            if (idx == LOAD_LAST)
              state <= S_START;
          end
        end
        S_START: begin
          idx   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (proc_ack) begin
            if (RES_LEN == 0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            cycle_count <= cnt_next;
            if (TIMEOUT != 0 && cnt_next == TIMEOUT_VAL) begin
              state     <= S_TIMEOUT;
              timed_out <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            idx <= idx + 32'd1;
            if (idx == RES_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_host_ctrl.sv
// Directed bench for proc_host_ctrl. Three instances share Clk/Reset:
//   a: LOAD_LEN=4, RES_LEN=2, default timeout (basic, backpressure, reset)
//   b: LOAD_LEN=0, RES_LEN=2, TIMEOUT=8       (timeout, ack on boundary)
//   c: LOAD_LEN=0, RES_LEN=0, TIMEOUT=0       (zero-length windows)
module tb_proc_host_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  int nchecks = 0;
  int nfail   = 0;

  // ---------------- instance a ----------------
  logic        a_start, a_in_valid, a_in_ready, a_proc_init, a_proc_req, a_proc_ack;
  logic        a_mem_we, a_out_valid, a_out_ready, a_busy, a_done, a_timed_out;
  logic [7:0]  a_in_data, a_mem_addr, a_mem_wdata, a_mem_rdata, a_out_data;
  logic [31:0] a_cycle_count;
  logic [7:0]  mem_a [256];
  logic [7:0]  src [4];
  logic [2:0]  src_idx;
  logic [7:0]  q_waddr [$];
  logic [7:0]  q_wdata [$];
  logic [7:0]  q_outa  [$];

  assign a_in_data   = src[src_idx[1:0]];
  assign a_mem_rdata = mem_a[a_mem_addr];

  proc_host_ctrl #(.LOAD_LEN(4), .RES_LEN(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .start(a_start),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .proc_init(a_proc_init), .proc_req(a_proc_req), .proc_ack(a_proc_ack),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .busy(a_busy), .done(a_done), .timed_out(a_timed_out), .cycle_count(a_cycle_count)
  );

  always @(posedge Clk) begin
    if (Reset) begin
      mem_a[64] <= 8'hA5;
      mem_a[65] <= 8'h5A;
    end else if (a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
    end
    if (a_start) begin
      src_idx <= '0;
      q_waddr.delete();
      q_wdata.delete();
      q_outa.delete();
    end else begin
      if (a_in_valid && a_in_ready) src_idx <= src_idx + 3'd1;
      if (a_mem_we) begin
        q_waddr.push_back(a_mem_addr);
        q_wdata.push_back(a_mem_wdata);
      end
      if (a_out_valid && a_out_ready) q_outa.push_back(a_out_data);
    end
  end

  // ---------------- instance b ----------------
  logic        b_start, b_in_ready, b_proc_init, b_proc_req, b_proc_ack;
  logic        b_mem_we, b_out_valid, b_out_ready, b_busy, b_done, b_timed_out;
  logic [7:0]  b_mem_addr, b_mem_wdata, b_mem_rdata, b_out_data;
  logic [31:0] b_cycle_count;
  logic [7:0]  q_outb [$];

  assign b_mem_rdata = ~b_mem_addr;

  proc_host_ctrl #(.LOAD_LEN(0), .RES_LEN(2), .TIMEOUT(8)) dut_b (
    .Clk(Clk), .Reset(Reset), .start(b_start),
    .in_valid(1'b0), .in_data(8'h00), .in_ready(b_in_ready),
    .proc_init(b_proc_init), .proc_req(b_proc_req), .proc_ack(b_proc_ack),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .busy(b_busy), .done(b_done), .timed_out(b_timed_out), .cycle_count(b_cycle_count)
  );

  always @(posedge Clk) begin
    if (b_start) q_outb.delete();
    else if (b_out_valid && b_out_ready) q_outb.push_back(b_out_data);
  end

  // ---------------- instance c ----------------
  logic        c_start, c_in_valid, c_in_ready, c_proc_init, c_proc_req, c_proc_ack;
  logic        c_mem_we, c_out_valid, c_out_ready, c_busy, c_done, c_timed_out;
  logic [7:0]  c_mem_addr, c_mem_wdata, c_out_data;
  logic [31:0] c_cycle_count;

  proc_host_ctrl #(.LOAD_LEN(0), .RES_LEN(0), .TIMEOUT(0)) dut_c (
    .Clk(Clk), .Reset(Reset), .start(c_start),
    .in_valid(c_in_valid), .in_data(8'h77), .in_ready(c_in_ready),
    .proc_init(c_proc_init), .proc_req(c_proc_req), .proc_ack(c_proc_ack),
    .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(8'h00),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
    .busy(c_busy), .done(c_done), .timed_out(c_timed_out), .cycle_count(c_cycle_count)
  );

  // Runs one job on instance a. Ack goes high ack_dly cycles after the req
  // cycle. Optional in_valid toggling and a 3-cycle out_ready stall on the
  // second result byte. Returns observations for the caller to check.
  task automatic run_job_a(input int ack_dly, input bit toggle_in, input bit stall_out,
                           output int init_n, output int req_n, output int stall_bad,
                           output bit ok);
    int r, dn;
    bit seen;
    init_n = 0; req_n = 0; stall_bad = 0; ok = 0; r = 0; dn = 0; seen = 0;
    a_proc_ack = 0; a_in_valid = 1; a_out_ready = 1;
    @(negedge Clk);
    a_start = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      a_start     = 0;
      a_in_valid  = toggle_in ? (i % 2 == 0) : 1'b1;
      a_out_ready = !(stall_out && dn >= 1 && dn <= 3);
      a_proc_ack  = seen && (i - r >= ack_dly);
      #1;
      if (a_proc_init) init_n++;
      if (a_proc_req) begin
        req_n++;
        if (!seen) begin seen = 1; r = i; end
      end
      if (a_out_valid) begin
        if (stall_out && dn >= 1 && dn <= 3 && (a_mem_addr !== 8'd65 || a_out_data !== 8'h5A))
          stall_bad++;
        dn++;
      end
      if (a_done) begin ok = 1; break; end
    end
    a_proc_ack = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    #1;
    nchecks++; if (a_proc_init !== 1'b1) begin nfail++; $display("FAIL reset_init_a: got %b want 1", a_proc_init); end
    nchecks++; if (b_proc_init !== 1'b1) begin nfail++; $display("FAIL reset_init_b: got %b want 1", b_proc_init); end
    nchecks++; if (a_busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    nchecks++; if (a_mem_we !== 1'b0 || a_in_ready !== 1'b0) begin nfail++; $display("FAIL reset_load_strobes: we=%b rdy=%b want 0 0", a_mem_we, a_in_ready); end
    nchecks++; if (a_proc_req !== 1'b0 || a_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_req_ov: req=%b ov=%b want 0 0", a_proc_req, a_out_valid); end
    Reset = 0;
    @(negedge Clk);
    #1;
    nchecks++; if (a_proc_init !== 1'b0) begin nfail++; $display("FAIL idle_init: got %b want 0", a_proc_init); end
    nchecks++; if (a_done !== 1'b0 || a_timed_out !== 1'b0) begin nfail++; $display("FAIL idle_flags: done=%b to=%b want 0 0", a_done, a_timed_out); end
    nchecks++; if (a_cycle_count !== 32'd0) begin nfail++; $display("FAIL idle_count: got %0d want 0", a_cycle_count); end
  endtask

  task automatic test_basic();
    int init_n, req_n, sb;
    bit ok;
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    run_job_a(11, 0, 0, init_n, req_n, sb, ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL basic_finish: done not seen within budget"); end
    nchecks++; if (init_n != 4) begin nfail++; $display("FAIL basic_init_cycles: got %0d want 4", init_n); end
    nchecks++; if (req_n != 1) begin nfail++; $display("FAIL basic_req_cycles: got %0d want 1", req_n); end
    nchecks++;
    if (q_waddr.size() != 4) begin
      nfail++; $display("FAIL basic_write_count: got %0d want 4", q_waddr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nchecks++;
        if (q_waddr[k] !== 8'(k) || q_wdata[k] !== src[k]) begin
          nfail++; $display("FAIL basic_write%0d: got addr %0h data %0h want %0h %0h", k, q_waddr[k], q_wdata[k], k, src[k]);
        end
      end
    end
    nchecks++; if (a_cycle_count !== 32'd10) begin nfail++; $display("FAIL basic_cycle_count: got %0d want 10", a_cycle_count); end
    nchecks++;
    if (q_outa.size() != 2 || q_outa[0] !== 8'hA5 || q_outa[1] !== 8'h5A) begin
      nfail++; $display("FAIL basic_out_bytes: got %p want A5 5A", q_outa);
    end
    nchecks++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_timed_out !== 1'b0) begin nfail++; $display("FAIL basic_status: done=%b busy=%b to=%b want 1 0 0", a_done, a_busy, a_timed_out); end
  endtask

  task automatic test_backpressure();
    int init_n, req_n, sb;
    bit ok;
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04;
    run_job_a(3, 1, 1, init_n, req_n, sb, ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL bp_finish: done not seen within budget"); end
    nchecks++;
    if (q_waddr.size() != 4) begin
      nfail++; $display("FAIL bp_write_count: got %0d want 4", q_waddr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nchecks++;
        if (q_waddr[k] !== 8'(k) || q_wdata[k] !== src[k]) begin
          nfail++; $display("FAIL bp_write%0d: got addr %0h data %0h want %0h %0h", k, q_waddr[k], q_wdata[k], k, src[k]);
        end
      end
    end
    nchecks++; if (sb != 0) begin nfail++; $display("FAIL bp_stall_stable: %0d unstable stall cycles want 0", sb); end
    nchecks++;
    if (q_outa.size() != 2 || q_outa[0] !== 8'hA5 || q_outa[1] !== 8'h5A) begin
      nfail++; $display("FAIL bp_out_bytes: got %p want A5 5A", q_outa);
    end
    nchecks++; if (a_cycle_count !== 32'd2) begin nfail++; $display("FAIL bp_cycle_count: got %0d want 2", a_cycle_count); end
  endtask

  task automatic test_timeout();
    int run_n, ov_n;
    bit fin;
    run_n = 0; ov_n = 0; fin = 0;
    b_proc_ack = 0; b_out_ready = 1;
    @(negedge Clk);
    b_start = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      b_start = 0;
      #1;
      if (b_busy && !b_proc_init && !b_proc_req) run_n++;
      if (b_out_valid) ov_n++;
      if (b_timed_out) begin fin = 1; break; end
    end
    nchecks++; if (!fin) begin nfail++; $display("FAIL to_reached: timed_out not seen within budget"); end
    nchecks++; if (run_n != 8) begin nfail++; $display("FAIL to_run_cycles: got %0d want 8", run_n); end
    nchecks++; if (b_cycle_count !== 32'd8) begin nfail++; $display("FAIL to_cycle_count: got %0d want 8", b_cycle_count); end
    nchecks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin nfail++; $display("FAIL to_status: busy=%b done=%b want 0 0", b_busy, b_done); end
    nchecks++; if (ov_n != 0) begin nfail++; $display("FAIL to_no_drain: got %0d out_valid cycles want 0", ov_n); end
  endtask

  task automatic test_ack_boundary();
    int r;
    bit seen, drained, fin;
    r = 0; seen = 0; drained = 0; fin = 0;
    b_proc_ack = 0; b_out_ready = 1;
    @(negedge Clk);
    b_start = 1;
    @(negedge Clk);
    b_start = 0;
    #1;
    nchecks++; if (b_timed_out !== 1'b0 || b_cycle_count !== 32'd0) begin nfail++; $display("FAIL restart_clear: to=%b cnt=%0d want 0 0", b_timed_out, b_cycle_count); end
    nchecks++; if (b_proc_init !== 1'b1) begin nfail++; $display("FAIL restart_init: got %b want 1", b_proc_init); end
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      b_proc_ack = seen && (i - r >= 8);
      #1;
      if (b_proc_req && !seen) begin seen = 1; r = i; end
      if (b_out_valid && !drained) begin
        drained = 1;
        nchecks++; if (b_timed_out !== 1'b0 || b_cycle_count !== 32'd7) begin nfail++; $display("FAIL ack_boundary_state: to=%b cnt=%0d want 0 7", b_timed_out, b_cycle_count); end
      end
      if (b_done || b_timed_out) begin fin = 1; break; end
    end
    b_proc_ack = 0;
    nchecks++; if (!drained || !fin) begin nfail++; $display("FAIL ack_boundary_drain: drained=%b finished=%b want 1 1", drained, fin); end
    nchecks++;
    if (q_outb.size() != 2 || q_outb[0] !== 8'hBF || q_outb[1] !== 8'hBE) begin
      nfail++; $display("FAIL ack_boundary_bytes: got %p want BF BE", q_outb);
    end
    nchecks++; if (b_done !== 1'b1 || b_timed_out !== 1'b0) begin nfail++; $display("FAIL ack_boundary_status: done=%b to=%b want 1 0", b_done, b_timed_out); end
  endtask

  task automatic test_reset_mid();
    int r, dn, init_n, req_n, sb;
    bit seen, hit, ok;
    r = 0; dn = 0; seen = 0; hit = 0;
    src[0] = 8'h10; src[1] = 8'h20; src[2] = 8'h30; src[3] = 8'h40;
    a_proc_ack = 0; a_in_valid = 1; a_out_ready = 1;
    @(negedge Clk);
    a_start = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      a_start    = 0;
      a_proc_ack = seen && (i - r >= 2);
      Reset      = (dn == 1);
      #1;
      if (Reset) begin
        hit = 1;
        nchecks++; if (a_proc_init !== 1'b1) begin nfail++; $display("FAIL midrst_init: got %b want 1", a_proc_init); end
        nchecks++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_ov_in_reset: got %b want 0", a_out_valid); end
        break;
      end
      if (a_proc_req && !seen) begin seen = 1; r = i; end
      if (a_out_valid) dn++;
    end
    nchecks++; if (!hit) begin nfail++; $display("FAIL midrst_reach_drain: drain idx 1 not reached"); end
    @(negedge Clk);
    Reset = 0; a_proc_ack = 0;
    #1;
    nchecks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_idle: busy=%b ov=%b want 0 0", a_busy, a_out_valid); end
    nchecks++; if (a_done !== 1'b0 || a_cycle_count !== 32'd0) begin nfail++; $display("FAIL midrst_clear: done=%b cnt=%0d want 0 0", a_done, a_cycle_count); end
    nchecks++; if (a_proc_init !== 1'b0) begin nfail++; $display("FAIL midrst_init_release: got %b want 0", a_proc_init); end
    nchecks++; if (q_outa.size() != 1) begin nfail++; $display("FAIL midrst_partial: got %0d bytes want 1", q_outa.size()); end
    run_job_a(4, 0, 0, init_n, req_n, sb, ok);
    nchecks++; if (!ok || a_done !== 1'b1) begin nfail++; $display("FAIL midrst_rerun_done: ok=%b done=%b want 1 1", ok, a_done); end
    nchecks++;
    if (q_outa.size() != 2 || q_outa[0] !== 8'hA5 || q_outa[1] !== 8'h5A) begin
      nfail++; $display("FAIL midrst_rerun_bytes: got %p want A5 5A", q_outa);
    end
    nchecks++; if (a_cycle_count !== 32'd3) begin nfail++; $display("FAIL midrst_rerun_count: got %0d want 3", a_cycle_count); end
  endtask

  task automatic test_zero_len();
    int r, init_n, req_n, we_n, ov_n;
    bit seen, fin;
    r = 0; init_n = 0; req_n = 0; we_n = 0; ov_n = 0; seen = 0; fin = 0;
    c_in_valid = 1; c_out_ready = 1; c_proc_ack = 0;
    @(negedge Clk);
    c_start = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      c_start    = (i == 1);
      c_proc_ack = seen && (i - r >= 3);
      #1;
      if (c_proc_init) init_n++;
      if (c_proc_req) begin
        req_n++;
        if (!seen) begin seen = 1; r = i; end
      end
      if (c_mem_we) we_n++;
      if (c_out_valid) ov_n++;
      if (c_done) begin fin = 1; break; end
    end
    c_start = 0; c_proc_ack = 0;
    nchecks++; if (!fin) begin nfail++; $display("FAIL zero_finish: done not seen within budget"); end
    nchecks++; if (init_n != 4) begin nfail++; $display("FAIL zero_init_cycles: got %0d want 4", init_n); end
    nchecks++; if (req_n != 1) begin nfail++; $display("FAIL zero_req_cycles: got %0d want 1", req_n); end
    nchecks++; if (we_n != 0 || ov_n != 0) begin nfail++; $display("FAIL zero_no_traffic: we=%0d ov=%0d want 0 0", we_n, ov_n); end
    nchecks++; if (c_cycle_count !== 32'd2) begin nfail++; $display("FAIL zero_cycle_count: got %0d want 2", c_cycle_count); end
    nchecks++; if (c_busy !== 1'b0) begin nfail++; $display("FAIL zero_busy: got %b want 0", c_busy); end
  endtask

  initial begin
    Reset = 1;
    a_start = 0; a_in_valid = 1; a_proc_ack = 0; a_out_ready = 1;
    b_start = 0; b_proc_ack = 0; b_out_ready = 1;
    c_start = 0; c_in_valid = 0; c_proc_ack = 0; c_out_ready = 1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_ack_boundary();
    test_reset_mid();
    test_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
